condlogic_it: RTL and testbench
===============================

// Module: condlogic_it
// PURPOSE
// Conditional-execution unit for the ARM-subset core, replacing the single-instruction condition check.
// Holds the NZCV flag register and gates RegWrite/MemWrite/PCSrc by the evaluated condition.
// Adds an IT-block tracker: after an IT instruction, up to IT_DEPTH following instructions take
// their condition from the IT base condition and mask (then/else) instead of their Cond field.
// Sits between the decoder and the datapath; all state advances only on committed instructions (Advance=1).
// PARAMETERS
// IT_DEPTH  4  max instructions covered by one IT block (>=1)
// CNT_W     $clog2(IT_DEPTH+1)  width of IT length/counter (derived, not overridden)
// PORTS
// clk       in   1         clock
// reset     in   1         async, active-high reset
// Advance   in   1         instruction commits this cycle; 0 = stall
// Cond      in   4         instruction condition field
// ALUFlags  in   4         {N,Z,C,V} from ALU
// FlagW     in   2         [1]=write NZ, [0]=write CV
// PCS       in   1         decoder: instruction writes PC
// RegW      in   1         decoder: instruction writes register file
// MemW      in   1         decoder: instruction writes memory
// ITLoad    in   1         current instruction is IT
// ITBase    in   4         IT first condition
// ITMask    in   IT_DEPTH  per-slot then(1)/else(0), bit0 = first slot
// ITLen     in   CNT_W     number of covered slots, 1..IT_DEPTH
// PCSrc     out  1         PCS & CondEx
// RegWrite  out  1         RegW & CondEx
// MemWrite  out  1         MemW & CondEx
// CondEx    out  1         effective condition passed and Advance=1
// Flags     out  4         registered {N,Z,C,V}
// ITActive  out  1         registered, it_cnt != 0
// ITFault   out  1         ITLoad while ITActive (combinational pulse)
// BEHAVIOUR
// - State: Flags[3:0], it_cnt[CNT_W-1:0], it_base[3:0], it_mask[IT_DEPTH-1:0].
// - Async reset: Flags=0, it_cnt=0, it_base=0, it_mask='1; while reset=1, PCSrc/RegWrite/MemWrite/CondEx=0.
// - EffCond = ITActive ? (it_mask[0] ? it_base : {it_base[3:1],~it_base[0]}) : Cond.
// - Check table (Z,NE,CS,CC,MI,PL,VS,VC,HI,LS,GE,LT,GT,LE,AL) for 0000..1110; 1111 -> fail (never X).
//   AL base with else slot yields 1111 -> slot not executed.
// - CondEx = Advance & check(EffCond, Flags); write outputs combinational, zero latency.
// - Flags edge update: NZ <= ALUFlags[3:2] if FlagW[1]&CondEx; CV <= ALUFlags[1:0] if FlagW[0]&CondEx.
//   Instruction in same cycle sees old Flags (no forwarding).
// - Advance=0: no register changes, all write outputs 0.
// - ITLoad & Advance & !ITActive: it_cnt<=min(ITLen,IT_DEPTH), it_base<=ITBase, it_mask<=ITMask;
//   ITLen=0 -> no block opened. Load independent of CondEx (decoder drives PCS/RegW/MemW=0 for IT).
// - Advance & ITActive: it_cnt<=it_cnt-1, it_mask<={1'b1,it_mask[IT_DEPTH-1:1]}.
// - PCSrc=1 in an IT slot: it_cnt<=0 (block terminates after branch).
// - ITLoad & ITActive: ITFault=1; load ignored; slot consumed as normal IT slot.
// - Reset mid-block: tracker and flags cleared immediately; next instruction uses its own Cond.
// STRUCTURE
// - cond_pkg: cond_e enum (EQ..AL,NV), flags_t struct {n,z,c,v}, function cond_pass(cond_e, flags_t).
// - One sub-module: it_tracker (it_cnt/it_base/it_mask registers, EffCond, ITActive, ITFault).
// - Top: flag registers, cond_pass, output gating.
// TESTING
// - Reset, Cond=1110, RegW=1, Advance=1 -> RegWrite=1, Flags=0000, ITActive=0.
// - FlagW=11, ALUFlags=0100 (Z), Cond=1110 -> Flags=0100 next cycle; then Cond=0000 RegW=1 -> RegWrite=1, Cond=0001 -> 0.
// - Flags=0100, ITLoad, ITBase=0000, ITMask=0101, ITLen=3; next 3 slots RegW=1, Cond=1110 -> RegWrite=1,0,1; 4th slot uses Cond.
// - IT block ITLen=4, slot 2 PCS=1 and passes -> PCSrc=1, ITActive=0 next cycle.
// - Advance=0 for 3 cycles mid-block -> it_cnt, Flags unchanged, all writes 0; resumes at same slot.
// - ITLoad during active block -> ITFault=1, block continues; Cond=1111 outside IT -> CondEx=0; reset mid-block -> ITActive=0.

Source files
------------

// File: rtl/condlogic_it_pkg.sv
// Shared types for the conditional-execution unit: condition codes,
// NZCV flag bundle and the condition check used by the gating logic.
package condlogic_it_pkg;

    typedef enum logic [3:0] {
        EQ = 4'b0000, NE = 4'b0001, CS = 4'b0010, CC = 4'b0011,
        MI = 4'b0100, PL = 4'b0101, VS = 4'b0110, VC = 4'b0111,
        HI = 4'b1000, LS = 4'b1001, GE = 4'b1010, LT = 4'b1011,
        GT = 4'b1100, LE = 4'b1101, AL = 4'b1110, NV = 4'b1111
    } cond_e;

    typedef struct packed {
        logic n;
        logic z;
        logic c;
        logic v;
    } flags_t;

    // NV is treated as "never" so a synthetic else-of-AL slot is skipped.
    function automatic logic cond_pass(input cond_e c, input flags_t f);
        logic r;
        r = 1'b0;
        case (c)
            EQ: r = f.z;
            NE: r = ~f.z;
            CS: r = f.c;
            CC: r = ~f.c;
            MI: r = f.n;
            PL: r = ~f.n;
            VS: r = f.v;
            VC: r = ~f.v;
            HI: r = f.c & ~f.z;
            LS: r = ~f.c | f.z;
            GE: r = (f.n == f.v);
            LT: r = (f.n != f.v);
            GT: r = ~f.z & (f.n == f.v);
            LE: r = f.z | (f.n != f.v);
            AL: r = 1'b1;
            default: r = 1'b0;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/condlogic_it_if.sv
// Decoder/datapath bundle of the conditional-execution unit.
// master = decoder side (drives controls), slave = condlogic_it.
interface condlogic_it_if #(
    parameter int IT_DEPTH = 4
);
    localparam int CNT_W = $clog2(IT_DEPTH + 1);

    logic                Advance;
    logic [3:0]          Cond;
    logic [3:0]          ALUFlags;
    logic [1:0]          FlagW;
    logic                PCS;
    logic                RegW;
    logic                MemW;
    logic                ITLoad;
    logic [3:0]          ITBase;
    logic [IT_DEPTH-1:0] ITMask;
    logic [CNT_W-1:0]    ITLen;

    logic                PCSrc;
    logic                RegWrite;
    logic                MemWrite;
    logic                CondEx;
    logic [3:0]          Flags;
    logic                ITActive;
    logic                ITFault;

    modport master (
        output Advance, Cond, ALUFlags, FlagW, PCS, RegW, MemW,
        output ITLoad, ITBase, ITMask, ITLen,
        input  PCSrc, RegWrite, MemWrite, CondEx, Flags,
        input  ITActive, ITFault
    );

    modport slave (
        input  Advance, Cond, ALUFlags, FlagW, PCS, RegW, MemW,
        input  ITLoad, ITBase, ITMask, ITLen,
        output PCSrc, RegWrite, MemWrite, CondEx, Flags,
        output ITActive, ITFault
    );

endinterface

// File: rtl/condlogic_it_tracker.sv
// IT-block tracker: holds remaining slot count, base condition and
// then/else mask; supplies the effective condition for each instruction.
// Ports: clk, reset, advance, cond, itload/itbase/itmask/itlen (IT load),
//        branch (slot redirected PC), eff_cond, it_active, it_fault.
module condlogic_it_tracker
    import condlogic_it_pkg::*;
#(
    parameter int IT_DEPTH = 4,
    localparam int CNT_W = $clog2(IT_DEPTH + 1)
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                advance,
    input  logic [3:0]          cond,
    input  logic                itload,
    input  logic [3:0]          itbase,
    input  logic [IT_DEPTH-1:0] itmask,
    input  logic [CNT_W-1:0]    itlen,
    input  logic                branch,
    output cond_e               eff_cond,
    output logic                it_active,
    output logic                it_fault
);

    localparam logic [CNT_W-1:0]    DEPTH_C = CNT_W'(IT_DEPTH);
    localparam logic [IT_DEPTH-1:0] MSB_C   = IT_DEPTH'(1) << (IT_DEPTH - 1);

    logic [CNT_W-1:0]    it_cnt;
    logic [3:0]          it_base;
    logic [IT_DEPTH-1:0] it_mask;

    assign it_active = (it_cnt != '0);
    assign it_fault  = itload & it_active;

    // Else slots invert the low bit of the base condition.
    always_comb begin
        eff_cond = cond_e'(cond);
        if (it_active)
            eff_cond = cond_e'(it_mask[0] ? it_base
                                          : {it_base[3:1], ~it_base[0]});
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            it_cnt  <= '0;
            it_base <= '0;
            it_mask <= '1;
        end else if (advance) begin
            if (it_active) begin
                // A taken branch inside the block ends it.
                it_cnt  <= branch ? '0 : it_cnt - 1'b1;
                it_mask <= (it_mask >> 1) | MSB_C;
            end else if (itload && itlen != '0) begin
                it_cnt  <= (itlen > DEPTH_C) ? DEPTH_C : itlen;
                it_base <= itbase;
                it_mask <= itmask;
            end
        end
    end

endmodule

// File: rtl/condlogic_it.sv
// Conditional-execution unit: NZCV flag register, condition check and
// write gating, with an IT-block tracker supplying slot conditions.
// Ports: clk, reset (async, active-high), bus (condlogic_it_if.slave).
module condlogic_it
    import condlogic_it_pkg::*;
#(
    parameter int IT_DEPTH = 4
) (
    input  logic         clk,
    input  logic         reset,
    condlogic_it_if.slave bus
);

    flags_t flags_q;
    cond_e  eff_cond;
    logic   condex;
    logic   pcsrc;
    logic   it_active;
    logic   it_fault;

    condlogic_it_tracker #(
        .IT_DEPTH (IT_DEPTH)
    ) u_trk (
        .clk       (clk),
        .reset     (reset),
        .advance   (bus.Advance),
        .cond      (bus.Cond),
        .itload    (bus.ITLoad),
        .itbase    (bus.ITBase),
        .itmask    (bus.ITMask),
        .itlen     (bus.ITLen),
        .branch    (pcsrc),
        .eff_cond  (eff_cond),
        .it_active (it_active),
        .it_fault  (it_fault)
    );

    // Reset gating keeps AL instructions from writing while held in reset.
    assign condex = bus.Advance & ~reset & cond_pass(eff_cond, flags_q);
    assign pcsrc  = bus.PCS & condex;

    assign bus.CondEx   = condex;
    assign bus.PCSrc    = pcsrc;
    assign bus.RegWrite = bus.RegW & condex;
    assign bus.MemWrite = bus.MemW & condex;
    assign bus.Flags    = flags_q;
    assign bus.ITActive = it_active;
    assign bus.ITFault  = it_fault;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            flags_q <= '0;
        end else if (condex) begin
            if (bus.FlagW[1]) {flags_q.n, flags_q.z} <= bus.ALUFlags[3:2];
            if (bus.FlagW[0]) {flags_q.c, flags_q.v} <= bus.ALUFlags[1:0];
        end
    end

endmodule

// File: tb/tb_condlogic_it.sv
// Scoreboard bench for condlogic_it: directed scenarios push expected
// output vectors and compare them against the DUT before the next edge.
module tb_condlogic_it;

    localparam int IT_DEPTH = 4;

    typedef struct packed {
        logic       adv;
        logic [3:0] cond;
        logic       regw;
        logic       memw;
        logic       pcs;
        logic [1:0] flagw;
        logic [3:0] aluf;
        logic       itl;
        logic [3:0] itb;
        logic [3:0] itm;
        logic [2:0] itn;
    } stim_t;

    logic clk = 1'b0;
    logic reset = 1'b1;
    int   n_checks = 0;
    int   n_fail = 0;

    logic [9:0] exp_q[$];

    condlogic_it_if #(.IT_DEPTH(IT_DEPTH)) bus ();

    condlogic_it #(.IT_DEPTH(IT_DEPTH)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    function automatic stim_t st(
        input logic adv, input logic [3:0] cond, input logic regw,
        input logic memw, input logic pcs, input logic [1:0] flagw,
        input logic [3:0] aluf, input logic itl, input logic [3:0] itb,
        input logic [3:0] itm, input logic [2:0] itn);
        stim_t s;
        s = '{adv, cond, regw, memw, pcs, flagw, aluf, itl, itb, itm, itn};
        return s;
    endfunction

    // {PCSrc,RegWrite,MemWrite,CondEx,Flags,ITActive,ITFault}
    function automatic logic [9:0] ex(
        input logic pc, input logic rw, input logic mw, input logic ce,
        input logic [3:0] fl, input logic act, input logic flt);
        return {pc, rw, mw, ce, fl, act, flt};
    endfunction

    function automatic logic [9:0] obs();
        return {bus.PCSrc, bus.RegWrite, bus.MemWrite, bus.CondEx,
                bus.Flags, bus.ITActive, bus.ITFault};
    endfunction

    task automatic drive(input stim_t s);
        bus.Advance  = s.adv;
        bus.Cond     = s.cond;
        bus.RegW     = s.regw;
        bus.MemW     = s.memw;
        bus.PCS      = s.pcs;
        bus.FlagW    = s.flagw;
        bus.ALUFlags = s.aluf;
        bus.ITLoad   = s.itl;
        bus.ITBase   = s.itb;
        bus.ITMask   = s.itm;
        bus.ITLen    = s.itn;
    endtask

    task automatic test_reset();
        logic [9:0] got, e;
        drive(st(1, 4'hE, 1, 0, 0, 2'b00, 4'h0, 0, 4'h0, 4'h0, 3'd0));
        exp_q.push_back(ex(0, 0, 0, 0, 4'h0, 0, 0));
        @(negedge clk);
        got = obs(); e = exp_q.pop_front(); n_checks++;
        if (got !== e) begin
            n_fail++;
            $display("FAIL reset_hold got=%b exp=%b", got, e);
        end
        @(posedge clk); #1 reset = 1'b0;
        exp_q.push_back(ex(0, 1, 0, 1, 4'h0, 0, 0));
        @(negedge clk);
        got = obs(); e = exp_q.pop_front(); n_checks++;
        if (got !== e) begin
            n_fail++;
            $display("FAIL reset_release got=%b exp=%b", got, e);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_flags();
        stim_t s[$];
        logic [9:0] got, e;
        logic [9:0] x[$];
        s.push_back(st(1, 4'hE, 0, 0, 0, 2'b11, 4'b0100, 0, 0, 0, 0));
        x.push_back(ex(0, 0, 0, 1, 4'b0000, 0, 0));
        s.push_back(st(1, 4'h0, 1, 0, 0, 2'b00, 4'h0, 0, 0, 0, 0));
        x.push_back(ex(0, 1, 0, 1, 4'b0100, 0, 0));
        s.push_back(st(1, 4'h1, 1, 0, 0, 2'b00, 4'h0, 0, 0, 0, 0));
        x.push_back(ex(0, 0, 0, 0, 4'b0100, 0, 0));
        s.push_back(st(1, 4'hE, 0, 0, 0, 2'b01, 4'b1011, 0, 0, 0, 0));
        x.push_back(ex(0, 0, 0, 1, 4'b0100, 0, 0));
        s.push_back(st(1, 4'h1, 1, 0, 0, 2'b11, 4'b1111, 0, 0, 0, 0));
        x.push_back(ex(0, 0, 0, 0, 4'b0111, 0, 0));
        s.push_back(st(1, 4'hE, 0, 0, 0, 2'b01, 4'b0000, 0, 0, 0, 0));
        x.push_back(ex(0, 0, 0, 1, 4'b0111, 0, 0));
        s.push_back(st(1, 4'hE, 0, 0, 0, 2'b00, 4'h0, 0, 0, 0, 0));
        x.push_back(ex(0, 0, 0, 1, 4'b0100, 0, 0));
        foreach (s[i]) begin
            drive(s[i]);
            exp_q.push_back(x[i]);
            @(negedge clk);
            got = obs(); e = exp_q.pop_front(); n_checks++;
            if (got !== e) begin
                n_fail++;
                $display("FAIL flags[%0d] got=%b exp=%b", i, got, e);
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_it_block();
        stim_t s[$];
        logic [9:0] got, e;
        logic [9:0] x[$];
        s.push_back(st(1, 4'hE, 0, 0, 0, 0, 0, 1, 4'h0, 4'b0101, 3'd3));
        x.push_back(ex(0, 0, 0, 1, 4'b0100, 0, 0));
        s.push_back(st(1, 4'hE, 1, 0, 0, 0, 0, 0, 0, 0, 0));
        x.push_back(ex(0, 1, 0, 1, 4'b0100, 1, 0));
        s.push_back(st(1, 4'hE, 1, 0, 0, 0, 0, 0, 0, 0, 0));
        x.push_back(ex(0, 0, 0, 0, 4'b0100, 1, 0));
        s.push_back(st(1, 4'hE, 1, 0, 0, 0, 0, 0, 0, 0, 0));
        x.push_back(ex(0, 1, 0, 1, 4'b0100, 1, 0));
        s.push_back(st(1, 4'h1, 1, 0, 0, 0, 0, 0, 0, 0, 0));
        x.push_back(ex(0, 0, 0, 0, 4'b0100, 0, 0));
        foreach (s[i]) begin
            drive(s[i]);
            exp_q.push_back(x[i]);
            @(negedge clk);
            got = obs(); e = exp_q.pop_front(); n_checks++;
            if (got !== e) begin
                n_fail++;
                $display("FAIL it_block[%0d] got=%b exp=%b", i, got, e);
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_branch();
        stim_t s[$];
        logic [9:0] got, e;
        logic [9:0] x[$];
        s.push_back(st(1, 4'hE, 0, 0, 0, 0, 0, 1, 4'h0, 4'b1111, 3'd4));
        x.push_back(ex(0, 0, 0, 1, 4'b0100, 0, 0));
        s.push_back(st(1, 4'hE, 1, 0, 0, 0, 0, 0, 0, 0, 0));
        x.push_back(ex(0, 1, 0, 1, 4'b0100, 1, 0));
        s.push_back(st(1, 4'hE, 0, 0, 1, 0, 0, 0, 0, 0, 0));
        x.push_back(ex(1, 0, 0, 1, 4'b0100, 1, 0));
        s.push_back(st(1, 4'h1, 1, 0, 0, 0, 0, 0, 0, 0, 0));
        x.push_back(ex(0, 0, 0, 0, 4'b0100, 0, 0));
        foreach (s[i]) begin
            drive(s[i]);
            exp_q.push_back(x[i]);
            @(negedge clk);
            got = obs(); e = exp_q.pop_front(); n_checks++;
            if (got !== e) begin
                n_fail++;
                $display("FAIL branch[%0d] got=%b exp=%b", i, got, e);
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_stall();
        stim_t s[$];
        logic [9:0] got, e;
        logic [9:0] x[$];
        s.push_back(st(1, 4'hE, 0, 0, 0, 0, 0, 1, 4'h1, 4'b0010, 3'd3));
        x.push_back(ex(0, 0, 0, 1, 4'b0100, 0, 0));
        s.push_back(st(1, 4'hE, 1, 0, 0, 0, 0, 0, 0, 0, 0));
        x.push_back(ex(0, 1, 0, 1, 4'b0100, 1, 0));
        for (int k = 0; k < 3; k++) begin
            s.push_back(st(0, 4'hE, 1, 1, 1, 2'b11, 4'b1000, 0, 0, 0, 0));
            x.push_back(ex(0, 0, 0, 0, 4'b0100, 1, 0));
        end
        s.push_back(st(1, 4'hE, 1, 0, 0, 0, 0, 0, 0, 0, 0));
        x.push_back(ex(0, 0, 0, 0, 4'b0100, 1, 0));
        s.push_back(st(1, 4'hE, 0, 1, 0, 0, 0, 0, 0, 0, 0));
        x.push_back(ex(0, 0, 1, 1, 4'b0100, 1, 0));
        s.push_back(st(1, 4'hE, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        x.push_back(ex(0, 0, 0, 1, 4'b0100, 0, 0));
        foreach (s[i]) begin
            drive(s[i]);
            exp_q.push_back(x[i]);
            @(negedge clk);
            got = obs(); e = exp_q.pop_front(); n_checks++;
            if (got !== e) begin
                n_fail++;
                $display("FAIL stall[%0d] got=%b exp=%b", i, got, e);
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_fault();
        stim_t s[$];
        logic [9:0] got, e;
        logic [9:0] x[$];
        s.push_back(st(1, 4'hE, 0, 0, 0, 0, 0, 1, 4'hE, 4'b0001, 3'd2));
        x.push_back(ex(0, 0, 0, 1, 4'b0100, 0, 0));
        s.push_back(st(1, 4'hE, 1, 0, 0, 0, 0, 1, 4'h0, 4'b0000, 3'd4));
        x.push_back(ex(0, 1, 0, 1, 4'b0100, 1, 1));
        s.push_back(st(1, 4'hE, 1, 0, 0, 0, 0, 0, 0, 0, 0));
        x.push_back(ex(0, 0, 0, 0, 4'b0100, 1, 0));
        s.push_back(st(1, 4'hF, 1, 0, 0, 0, 0, 0, 0, 0, 0));
        x.push_back(ex(0, 0, 0, 0, 4'b0100, 0, 0));
        foreach (s[i]) begin
            drive(s[i]);
            exp_q.push_back(x[i]);
            @(negedge clk);
            got = obs(); e = exp_q.pop_front(); n_checks++;
            if (got !== e) begin
                n_fail++;
                $display("FAIL fault[%0d] got=%b exp=%b", i, got, e);
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_len_bounds();
        stim_t s[$];
        logic [9:0] got, e;
        logic [9:0] x[$];
        s.push_back(st(1, 4'hE, 0, 0, 0, 0, 0, 1, 4'hE, 4'b0000, 3'd0));
        x.push_back(ex(0, 0, 0, 1, 4'b0100, 0, 0));
        s.push_back(st(1, 4'hE, 0, 0, 0, 0, 0, 1, 4'hE, 4'b1111, 3'd7));
        x.push_back(ex(0, 0, 0, 1, 4'b0100, 0, 0));
        for (int k = 0; k < IT_DEPTH; k++) begin
            s.push_back(st(1, 4'h1, 1, 0, 0, 0, 0, 0, 0, 0, 0));
            x.push_back(ex(0, 1, 0, 1, 4'b0100, 1, 0));
        end
        s.push_back(st(1, 4'h1, 1, 0, 0, 0, 0, 0, 0, 0, 0));
        x.push_back(ex(0, 0, 0, 0, 4'b0100, 0, 0));
        foreach (s[i]) begin
            drive(s[i]);
            exp_q.push_back(x[i]);
            @(negedge clk);
            got = obs(); e = exp_q.pop_front(); n_checks++;
            if (got !== e) begin
                n_fail++;
                $display("FAIL len_bounds[%0d] got=%b exp=%b", i, got, e);
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_reset_mid();
        stim_t s[$];
        logic [9:0] got, e;
        logic [9:0] x[$];
        s.push_back(st(1, 4'hE, 0, 0, 0, 0, 0, 1, 4'h1, 4'b1111, 3'd4));
        x.push_back(ex(0, 0, 0, 1, 4'b0100, 0, 0));
        s.push_back(st(1, 4'hE, 1, 0, 0, 0, 0, 0, 0, 0, 0));
        x.push_back(ex(0, 0, 0, 0, 4'b0100, 1, 0));
        foreach (s[i]) begin
            drive(s[i]);
            exp_q.push_back(x[i]);
            @(negedge clk);
            got = obs(); e = exp_q.pop_front(); n_checks++;
            if (got !== e) begin
                n_fail++;
                $display("FAIL reset_mid[%0d] got=%b exp=%b", i, got, e);
            end
            @(posedge clk); #1;
        end
        drive(st(1, 4'hE, 1, 0, 0, 0, 0, 0, 0, 0, 0));
        #1 reset = 1'b1;
        exp_q.push_back(ex(0, 0, 0, 0, 4'b0000, 0, 0));
        @(negedge clk);
        got = obs(); e = exp_q.pop_front(); n_checks++;
        if (got !== e) begin
            n_fail++;
            $display("FAIL reset_mid_hold got=%b exp=%b", got, e);
        end
        @(posedge clk); #1 reset = 1'b0;
        exp_q.push_back(ex(0, 1, 0, 1, 4'b0000, 0, 0));
        @(negedge clk);
        got = obs(); e = exp_q.pop_front(); n_checks++;
        if (got !== e) begin
            n_fail++;
            $display("FAIL reset_mid_after got=%b exp=%b", got, e);
        end
        @(posedge clk); #1;
    endtask

    initial begin
        drive(st(0, 4'hE, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        test_reset();
        test_flags();
        test_it_block();
        test_branch();
        test_stall();
        test_fault();
        test_len_bounds();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
